ps2_ascii_rx: RTL and testbench

PS2_ASCII_RX -- requirements
Module: ps2_ascii_rx

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_frame_rx.sv | 140 ++++++++++++++
 rtl/ps2_ascii_rx.sv | 146 ++++++++++++++
 tb/tb_ps2_ascii_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg -- shared definitions for the PS/2 keyboard receiver.
//   * PS/2 set-2 prefix bytes and shift make codes
//   * frame FSM state encoding
//   * FIFO entry layout {ext, scan, ascii}
//   * scan_to_ascii(): set-2 make code to 7-bit ASCII (0x00 when unmapped)
// -----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] scan;
        logic [6:0] ascii;
    } fifo_entry_t;

    // Letters come out uppercase; 'lower' folds them to lowercase.
    // Every E0-prefixed code maps to 0x00.
    function automatic logic [6:0] scan_to_ascii(input logic [7:0] scan,
                                                 input logic       ext,
                                                 input logic       lower);
        logic [6:0] a;
        a = 7'h00;
        case (scan)
            8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
            8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
            8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
            8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
            8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
            8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
            8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
            8'h45: a = 7'h30;  8'h16: a = 7'h31;  8'h1E: a = 7'h32;  8'h26: a = 7'h33;
            8'h25: a = 7'h34;  8'h2E: a = 7'h35;  8'h36: a = 7'h36;  8'h3D: a = 7'h37;
            8'h3E: a = 7'h38;  8'h46: a = 7'h39;
            8'h29: a = 7'h20;
            8'h5A: a = 7'h0D;
            8'h66: a = 7'h08;
            default: a = 7'h00;
        endcase
        if (lower && (a >= 7'h41) && (a <= 7'h5A))
            a = a + 7'h20;
        if (ext)
            a = 7'h00;
        return a;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// -----------------------------------------------------------------------------
// ps2_frame_rx -- PS/2 line receiver: synchroniser, ps2_clk glitch filter,
// 11-bit frame FSM (start, 8 data LSB first, odd parity, stop) and idle timeout.
//
// Ports
//   clk, resetn          system clock, synchronous active-low reset
//   ps2_clk, ps2_dat     raw asynchronous keyboard lines
//   byte_valid           one-cycle strobe, byte_data holds an accepted byte
//   byte_data[7:0]       last accepted byte
//   frame_err            one-cycle pulse per rejected frame
// -----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt_clk;
    logic [CW-1:0] filt_cnt;
    logic          fall;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Lines idle high, so the synchroniser and filter reset to 1: leaving
    // reset never fabricates a falling edge.
    // The filter only moves after FILTER_LEN consecutive samples disagree
    // with it; 'fall' is a registered one-cycle strobe of the 1->0 change.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fall     <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + CW'(1);
            end
        end
    end

    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] timer;
    logic          shift_en, par_en, accept, reject, timeout;

    assign timeout = (state_q != ST_IDLE) && !fall && (timer == TIME_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        shift_en = 1'b0;
        par_en   = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            reject  = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (dat_s) reject  = 1'b1;     // start bit must be 0
                    else       state_d = ST_DATA;
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_en  = 1'b1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    // Parity and stop are judged together so a bad frame
                    // raises exactly one frame_err pulse.
                    state_d = ST_IDLE;
                    if (dat_s && (^{shreg, par_bit})) accept = 1'b1;
                    else                              reject = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_valid <= accept;
            frame_err  <= reject;
            if (accept)   byte_data <= shreg;
            if (shift_en) shreg     <= {dat_s, shreg[7:1]};
            if (par_en)   par_bit   <= dat_s;
            if (state_q != ST_DATA) bit_cnt <= '0;
            else if (shift_en)      bit_cnt <= bit_cnt + 3'd1;
            if ((state_q == ST_IDLE) || fall) timer <= '0;
            else                              timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_ascii_rx.sv
// -----------------------------------------------------------------------------
// ps2_ascii_rx -- PS/2 keyboard receiver with set-2 prefix decoding, ASCII
// mapping and an output FIFO of make events {ext, scan, ascii}.
//
// Ports
//   clk, resetn            system clock, synchronous active-low reset
//   ps2_clk, ps2_dat       raw asynchronous keyboard lines
//   out_valid/out_ready    FIFO head handshake (pop when both high)
//   out_scan, out_ext,
//   out_ascii              head entry fields (0 while empty)
//   frame_err              one-cycle pulse per rejected frame
//   overflow               sticky: a make event was dropped on a full FIFO
//   fifo_count             occupied entries
//
// Build option: define PS2_SHIFT_CASE_EN to track left/right shift and emit
// lowercase letters unless a shift is held. Undefined: letters uppercase.
// -----------------------------------------------------------------------------
module ps2_ascii_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ps2_clk,
    input  logic                        ps2_dat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_scan,
    output logic                        out_ext,
    output logic [6:0]                  out_ascii,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic       byte_valid;
    logic [7:0] byte_data;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // ---------------- prefix / shift tracking ----------------
    logic ext_q, brk_q, lower;

`ifdef PS2_SHIFT_CASE_EN
    logic shift_l_q, shift_r_q;

    assign lower = !(shift_l_q || shift_r_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
        end else if (byte_valid && !ext_q) begin
            if (byte_data == PS2_LSHIFT) shift_l_q <= !brk_q;
            if (byte_data == PS2_RSHIFT) shift_r_q <= !brk_q;
        end
    end
`else
    assign lower = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == PS2_EXT)      ext_q <= 1'b1;
            else if (byte_data == PS2_BRK) brk_q <= 1'b1;
            else begin
                // Any other byte completes the key event (make or break).
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    logic        is_make;
    fifo_entry_t push_entry;

    always_comb begin
        is_make = byte_valid && (byte_data != PS2_EXT) && (byte_data != PS2_BRK) && !brk_q;
        push_entry.ext   = ext_q;
        push_entry.scan  = byte_data;
        push_entry.ascii = scan_to_ascii(byte_data, ext_q, lower);
    end

    // ---------------- output FIFO ----------------
    fifo_entry_t   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          full, pop, push;

    assign full      = (count_q == DEPTH_CNT);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves the same cycle.
    assign push      = is_make && (!full || pop);

    // NOTE: the storage array has no reset; only pointers and count do, and
    // the head fields are gated by out_valid so stale contents never show.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (is_make && full && !pop) overflow <= 1'b1;
        end
    end

    assign fifo_count = count_q;
    assign out_scan   = out_valid ? mem[rd_ptr].scan  : 8'h00;
    assign out_ext    = out_valid ? mem[rd_ptr].ext   : 1'b0;
    assign out_ascii  = out_valid ? mem[rd_ptr].ascii : 7'h00;

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_ascii_rx -- scoreboard bench for ps2_ascii_rx. Stimulus pushes the
// expected {ext, scan, ascii} for each make frame into a queue; the monitor
// pops and compares on every out_valid && out_ready cycle and counts
// frame_err pulses. Expectations follow PS2_SHIFT_CASE_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_ascii_rx;

    localparam int FIFO_DEPTH  = 8;
    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 20;   // clk cycles per ps2_clk half period

`ifdef PS2_SHIFT_CASE_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       out_ready = 1'b1;
    logic       out_valid, out_ext, frame_err, overflow;
    logic [7:0] out_scan;
    logic [6:0] out_ascii;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    ps2_ascii_rx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_scan   (out_scan),
        .out_ext    (out_ext),
        .out_ascii  (out_ascii),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Uppercase letter as the default build emits it; lowercase when shift
    // tracking is built in and no shift is held.
    function automatic logic [6:0] lc(input logic [6:0] up);
        return SHIFT_EN ? up + 7'h20 : up;
    endfunction

    // Monitor: scoreboard compare on every pop, count frame_err pulses.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame_err) err_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got 0x%0h expected none",
                             {out_ext, out_scan, out_ascii});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fifo_entry", {16'h0, out_ext, out_scan, out_ascii}, {16'h0, mon_exp});
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(bad_par ? (^b) : ~(^b));
        ps2_bit(!bad_stop);
        ps2_dat = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic make(input logic ext, input logic [7:0] scan, input logic [6:0] ascii);
        exp_q.push_back({ext, scan, ascii});
        send_frame(scan, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_err(input string name);
        check(name, err_cnt, exp_err);
    endtask

    logic [7:0] ov_scan [9];

    initial begin
        ov_scan = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_head", {out_ext, out_scan, out_ascii}, 0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        // ---- make / break of 'A' ----
        make(1'b0, 8'h1C, lc(7'h41));
        frame(8'hF0);
        frame(8'h1C);
        wait_drain("drain_make_break");
        check("count_after_break", fifo_count, 0);

        // ---- extended key ----
        frame(8'hE0);
        make(1'b1, 8'h75, 7'h00);
        wait_drain("drain_ext");

        // ---- parity error, then the same byte clean ----
        send_frame(8'h16, 1'b1, 1'b0);
        exp_err++;
        check_err("err_parity");
        make(1'b0, 8'h16, 7'h31);
        wait_drain("drain_after_parity");

        // ---- start bit 1 in IDLE ----
        ps2_bit(1'b1);
        repeat (2*HALF) @(negedge clk);
        exp_err++;
        check_err("err_start_bit");

        // ---- stop bit 0 ----
        send_frame(8'h1E, 1'b0, 1'b1);
        exp_err++;
        check_err("err_stop_bit");
        make(1'b0, 8'h1E, 7'h32);
        wait_drain("drain_after_stop");

        // ---- timeout after 5 data bits ----
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        repeat (TIMEOUT_CYC + 100) @(negedge clk);
        exp_err++;
        check_err("err_timeout");
        make(1'b0, 8'h29, 7'h20);
        wait_drain("drain_after_timeout");

        // ---- shift handling (left then right) ----
        make(1'b0, 8'h12, 7'h00);
        make(1'b0, 8'h1C, 7'h41);
        frame(8'hF0); frame(8'h12);
        make(1'b0, 8'h1C, lc(7'h41));
        make(1'b0, 8'h59, 7'h00);
        make(1'b0, 8'h1A, 7'h5A);
        frame(8'hF0); frame(8'h59);
        make(1'b0, 8'h1A, lc(7'h5A));
        wait_drain("drain_shift");

        // ---- misc map entries, extended break, ext clear ----
        make(1'b0, 8'h5A, 7'h0D);
        make(1'b0, 8'h66, 7'h08);
        make(1'b0, 8'h45, 7'h30);
        make(1'b0, 8'h46, 7'h39);
        make(1'b0, 8'h76, 7'h00);
        frame(8'hE0);
        make(1'b1, 8'h5A, 7'h00);
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        make(1'b0, 8'h1C, lc(7'h41));
        wait_drain("drain_misc");

        // ---- overflow: FIFO_DEPTH+1 makes with out_ready low ----
        out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            if (i < FIFO_DEPTH) exp_q.push_back({1'b0, ov_scan[i], lc(7'h41 + 7'(i))});
            send_frame(ov_scan[i], 1'b0, 1'b0);
        end
        check("ov_fifo_count", fifo_count, FIFO_DEPTH);
        check("ov_overflow", overflow, 1);
        check("ov_head_hold", {out_ext, out_scan, out_ascii}, {1'b0, 8'h1C, lc(7'h41)});
        out_ready = 1'b1;
        wait_drain("drain_overflow");
        check("ov_count_empty", fifo_count, 0);
        check("ov_sticky", overflow, 1);

        // ---- reset mid-frame ----
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_count", fifo_count, 0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        make(1'b0, 8'h29, 7'h20);
        wait_drain("drain_after_reset");

        check_err("err_total");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
